// File: rtl/alu_mdu_pkg.sv
// Shared types for the alu_mdu_seq execute unit: operation codes, FSM states
// and the single-cycle / multi-cycle classification.
package alu_mdu_pkg;

    typedef enum logic [4:0] {
        ADD    = 5'd0,
        SUB    = 5'd1,
        SLL    = 5'd2,
        SLT    = 5'd3,
        SLTU   = 5'd4,
        XOR    = 5'd5,
        SRL    = 5'd6,
        SRA    = 5'd7,
        OR     = 5'd8,
        AND    = 5'd9,
        EQ     = 5'd10,
        NE     = 5'd11,
        LT     = 5'd12,
        GE     = 5'd13,
        LTU    = 5'd14,
        GEU    = 5'd15,
        MUL    = 5'd16,
        MULH   = 5'd17,
        MULHSU = 5'd18,
        MULHU  = 5'd19,
        DIV    = 5'd20,
        DIVU   = 5'd21,
        REM    = 5'd22,
        REMU   = 5'd23
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Codes 24..31 are not listed, so they fall through to the ALU as ADD.
    function automatic logic is_long(input op_e op);
        return op inside {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU};
    endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative multiply/divide datapath: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, followed by a one-cycle sign/select fix-up.
module alu_mdu_iter
    import alu_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            start,
    input  op_e             op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            step,
    input  logic            fix,
    output logic            last,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);

    op_e               op_q;
    logic              neg_q;
    logic              div0_q;
    logic [XLEN-1:0]   a_raw;
    logic [XLEN-1:0]   b_mag;
    logic [2*XLEN:0]   prod;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   quo;
    logic [CNT_W-1:0]  cnt;

    logic              a_neg;
    logic              b_neg;
    logic              res_neg;
    logic [XLEN-1:0]   a_mag_in;
    logic [XLEN-1:0]   b_mag_in;

    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        a_neg   = 1'b0;
        b_neg   = 1'b0;
        res_neg = 1'b0;
        case (op)
            MULH, DIV, REM: begin
                a_neg = src1[XLEN-1];
                b_neg = src2[XLEN-1];
            end
            MULHSU:  a_neg = src1[XLEN-1];
            default: ;
        endcase
        case (op)
            MULH, MULHSU, DIV: res_neg = a_neg ^ b_neg;
            REM:               res_neg = a_neg;
            default:           res_neg = 1'b0;
        endcase
        a_mag_in = a_neg ? -src1 : src1;
        b_mag_in = b_neg ? -src2 : src2;
    end

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic            div_ge;
    logic [2*XLEN-1:0] prod_full;
    logic [2*XLEN-1:0] prod_signed;

    assign mul_sum     = prod[2*XLEN:XLEN] + {1'b0, (prod[0] ? b_mag : '0)};
    assign div_shift   = {rem, quo[XLEN-1]};
    assign div_diff    = div_shift - {1'b0, b_mag};
    assign div_ge      = div_shift >= {1'b0, b_mag};
    assign prod_full   = prod[2*XLEN-1:0];
    assign prod_signed = neg_q ? -prod_full : prod_full;
    assign last        = (cnt == CNT_W'(XLEN - 1));

    // NOTE: datapath registers carry no reset; the owning FSM reloads them on
    // start and never consumes them outside CALC/FIX, so reset would add nothing.
    always_ff @(posedge clk) begin
        if (start) begin
            op_q   <= op;
            neg_q  <= res_neg;
            div0_q <= (src2 == '0);
            a_raw  <= src1;
            b_mag  <= b_mag_in;
            prod   <= {{(XLEN+1){1'b0}}, a_mag_in};
            quo    <= a_mag_in;
            rem    <= '0;
            cnt    <= '0;
        end else if (step) begin
            // Both engines advance every step; fix picks whichever the op needs.
            cnt  <= cnt + 1'b1;
            prod <= {1'b0, mul_sum, prod[XLEN-1:1]};
            rem  <= div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            quo  <= {quo[XLEN-2:0], div_ge};
        end else if (fix) begin
            case (op_q)
                MUL:                 result <= prod_full[XLEN-1:0];
                MULH, MULHSU, MULHU: result <= prod_signed[2*XLEN-1:XLEN];
                DIV, DIVU:           result <= div0_q ? '1 : (neg_q ? -quo : quo);
                REM, REMU:           result <= div0_q ? a_raw : (neg_q ? -rem : rem);
                default:             result <= '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_mdu_seq.sv
// RV32IM-class execute unit: single-cycle ALU and compares, iterative mul/div,
// valid/ready handshake on both sides and a registered output stage.
module alu_mdu_seq
    import alu_mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_e              op,
    input  logic [XLEN-1:0]  src1,
    input  logic [XLEN-1:0]  src2,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out,
    output logic             busy
);

    localparam int SH_W = $clog2(XLEN);

    state_e           state;
    logic [TAG_W-1:0] pend_tag;
    logic [XLEN-1:0]  alu_res;
    logic [XLEN-1:0]  iter_res;
    logic             iter_last;
    logic             accept;
    logic             out_free;
    logic [SH_W-1:0]  shamt;

    assign out_free = !out_valid || out_ready;
    assign in_ready = reset && (state == IDLE) && out_free;
    assign accept   = in_valid && in_ready;
    assign shamt    = src2[SH_W-1:0];

    always_comb begin
        alu_res = src1 + src2;
        case (op)
            SUB:  alu_res = src1 - src2;
            SLL:  alu_res = src1 << shamt;
            SLT:  alu_res = XLEN'($signed(src1) < $signed(src2));
            SLTU: alu_res = XLEN'(src1 < src2);
            XOR:  alu_res = src1 ^ src2;
            SRL:  alu_res = src1 >> shamt;
            SRA:  alu_res = $signed(src1) >>> shamt;
            OR:   alu_res = src1 | src2;
            AND:  alu_res = src1 & src2;
            EQ:   alu_res = XLEN'(src1 == src2);
            NE:   alu_res = XLEN'(src1 != src2);
            LT:   alu_res = XLEN'($signed(src1) < $signed(src2));
            GE:   alu_res = XLEN'($signed(src1) >= $signed(src2));
            LTU:  alu_res = XLEN'(src1 < src2);
            GEU:  alu_res = XLEN'(src1 >= src2);
            default: ;
        endcase
    end

    alu_mdu_iter #(.XLEN(XLEN)) u_iter (
        .clk    (clk),
        .start  (accept && is_long(op)),
        .op     (op),
        .src1   (src1),
        .src2   (src2),
        .step   (state == CALC),
        .fix    (state == FIX),
        .last   (iter_last),
        .result (iter_res)
    );

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values and ordering inside the block does not matter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            tag_out   <= '0;
            busy      <= 1'b0;
            pend_tag  <= '0;
        end else begin
            // Single-cycle results and DONE loads are exclusive: one needs IDLE.
            if (accept && !is_long(op)) begin
                out_valid <= 1'b1;
                result    <= alu_res;
                tag_out   <= tag_in;
            end else if (state == DONE && out_free) begin
                out_valid <= 1'b1;
                result    <= iter_res;
                tag_out   <= pend_tag;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: if (accept && is_long(op)) begin
                    state    <= CALC;
                    busy     <= 1'b1;
                    pend_tag <= tag_in;
                end
                CALC: if (iter_last) state <= FIX;
                FIX:  state <= DONE;
                DONE: if (out_free) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed bench for alu_mdu_seq (XLEN=32): reset, ALU streaming, mul/div
// corners with latency, backpressure and mid-operation abort.
module tb_alu_mdu_seq;
    import alu_mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    op_e         op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  tag_out;
    logic        busy;

    int total = 0;
    int bad   = 0;

    alu_mdu_seq #(.XLEN(32), .TAG_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .tag_out   (tag_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", name, observed, expected);
        end
    endtask

    task automatic present(input op_e o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
        op       = o;
        src1     = a;
        src2     = b;
        tag_in   = t;
        in_valid = 1'b1;
    endtask

    // Issue one single-cycle op and expect its result right after the edge.
    task automatic run_short(input string name, input op_e o, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] t, input logic [31:0] exp);
        present(o, a, b, t);
        tick();
        check({name, " valid"}, 32'(out_valid), 32'd1);
        check({name, " result"}, result, exp);
        check({name, " tag"}, 32'(tag_out), 32'(t));
    endtask

    // Issue one long op, count cycles from the accepting edge to out_valid.
    task automatic run_long(input string name, input op_e o, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] t, input logic [31:0] exp);
        int   n;
        logic busy_all;
        present(o, a, b, t);
        check({name, " in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        n        = 0;
        busy_all = 1'b1;
        while (!out_valid && n < 60) begin
            busy_all &= busy;
            tick();
            n++;
        end
        check({name, " latency"}, 32'(n), 32'd34);
        check({name, " busy"}, 32'(busy_all), 32'd1);
        check({name, " result"}, result, exp);
        check({name, " tag"}, 32'(tag_out), 32'(t));
        tick();
    endtask

    initial begin
        int   watch;
        logic saw_valid;

        reset     = 1'b0;
        out_ready = 1'b1;
        present(ADD, 32'd1, 32'd1, 5'd0);
        repeat (3) tick();
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst result", result, 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst busy", 32'(busy), 32'd0);

        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        check("post-rst in_ready", 32'(in_ready), 32'd1);
        check("post-rst out_valid", 32'(out_valid), 32'd0);

        // Back-to-back single-cycle ops, one per clock.
        run_short("sub", SUB, 32'd5, 32'd7, 5'd1, 32'hFFFF_FFFE);
        run_short("sra", SRA, 32'h8000_0000, 32'd4, 5'd2, 32'hF800_0000);
        run_short("sltu", SLTU, 32'hFFFF_FFFF, 32'd1, 5'd3, 32'd0);
        run_short("slt", SLT, 32'hFFFF_FFFF, 32'd1, 5'd4, 32'd1);
        run_short("sll shamt mask", SLL, 32'd1, 32'd33, 5'd5, 32'd2);
        run_short("geu", GEU, 32'd3, 32'hFFFF_FFFF, 5'd6, 32'd0);
        run_short("undef op", op_e'(5'd30), 32'd4, 32'd5, 5'd7, 32'd9);
        in_valid = 1'b0;
        tick();
        check("stream drain", 32'(out_valid), 32'd0);

        run_long("mulh", MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'd0);
        run_long("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'hFFFF_FFFE);
        run_long("mul", MUL, 32'h1234_5678, 32'h10, 5'd10, 32'h2345_6780);
        run_long("mulhsu", MULHSU, 32'hFFFF_FFFD, 32'd5, 5'd11, 32'hFFFF_FFFF);
        run_long("div by 0", DIV, 32'd7, 32'd0, 5'd12, 32'hFFFF_FFFF);
        run_long("remu by 0", REMU, 32'd7, 32'd0, 5'd13, 32'd7);
        run_long("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000);
        run_long("rem ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0);
        run_long("div neg", DIV, 32'hFFFF_FFF9, 32'd2, 5'd16, 32'hFFFF_FFFD);
        run_long("rem neg", REM, 32'hFFFF_FFF9, 32'd2, 5'd17, 32'hFFFF_FFFF);
        run_long("divu", DIVU, 32'd100, 32'd7, 5'd18, 32'd14);
        check("idle after long", 32'(busy), 32'd0);

        // Backpressure: held output blocks the next op until out_ready.
        out_ready = 1'b0;
        present(ADD, 32'd1, 32'd2, 5'd19);
        tick();
        present(XOR, 32'd6, 32'd3, 5'd20);
        check("bp result", result, 32'd3);
        check("bp in_ready", 32'(in_ready), 32'd0);
        repeat (2) tick();
        check("bp held valid", 32'(out_valid), 32'd1);
        check("bp held result", result, 32'd3);
        check("bp held tag", 32'(tag_out), 32'd19);
        out_ready = 1'b1;
        #1;
        check("bp release ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp second result", result, 32'd5);
        check("bp second tag", 32'(tag_out), 32'd20);
        tick();
        check("bp drain", 32'(out_valid), 32'd0);

        // Abort a DIVU partway through with reset.
        present(DIVU, 32'd100, 32'd7, 5'd21);
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        check("abort busy before", 32'(busy), 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort busy", 32'(busy), 32'd0);
        saw_valid = 1'b0;
        for (watch = 0; watch < 40; watch++) begin
            saw_valid |= out_valid;
            tick();
        end
        check("abort no output", 32'(saw_valid), 32'd0);
        run_short("add after abort", ADD, 32'd1, 32'd1, 5'd22, 32'd2);
        in_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
